// File: rtl/stage4_mem_pkg.sv
// stage4_mem_pkg: shared definitions for the memory-access stage.
// Holds the controller state encoding, the read data reported on a
// timed-out access, the write-back register bundle and the branch rule.
package stage4_mem_pkg;

  // Memory-access controller states.
  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // Read data written back when an access times out.
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

  // Everything registered toward the write-back stage.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_rd_data;
    logic [4:0]  reg_wr_addr;
    logic        reg_write;
    logic        mem_to_reg;
  } wb_t;

  // Branch is taken when any enabled condition matches its ALU flag.
  function automatic logic branch_taken(
    input logic beq,
    input logic bne,
    input logic bgt,
    input logic zero,
    input logic not_zero,
    input logic greater
  );
    return (beq & zero) | (bne & not_zero) | (bgt & greater);
  endfunction

endpackage

// File: rtl/stage4_mem_if.sv
// stage4_mem_if: req/ack data-memory port between the memory stage
// (master) and the data memory (slave).
interface stage4_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/stage4_mem_ctrl.sv
// stage4_mem_ctrl: request controller for the memory stage.
// Tracks an outstanding access (IDLE/WAIT), runs the watchdog counter,
// and produces stall, the timeout strobe and the registered bus_err pulse.
// CNT_W must be wide enough that 2**CNT_W > TIMEOUT.
module stage4_mem_ctrl
  import stage4_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic op_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic timeout_o,
  output logic bus_err_o
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q;
  logic             timeout;

  // The watchdog fires on the last allowed WAIT cycle unless the ack
  // arrives in that same cycle, in which case the ack wins.
  assign timeout = (state_q == MEM_WAIT) &&
                   (cnt_q == CNT_W'(TIMEOUT - 1)) && !ack_i;

  // Request is purely the decoded operation; upstream holds it stable.
  assign req_o     = op_i;
  assign stall_o   = op_i & ~ack_i & ~timeout;
  assign timeout_o = timeout;
  assign bus_err_o = bus_err_q;

  // Next-state and watchdog counter update.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (op_i && !ack_i) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (ack_i || timeout) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and bus_err pulse registers.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rstb) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= timeout;
    end
  end

endmodule

// File: rtl/stage4_mem.sv
// stage4_mem: memory-access stage of the five-stage pipeline.
// Drives the data-memory port, resolves branches combinationally,
// stalls upstream while an access is outstanding and registers results
// toward write-back. Defining ALIGN_CHECK_EN adds a misalign output that
// blocks unaligned accesses and reports them as a one-cycle pulse.
module stage4_mem
  import stage4_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        regB_rd_data,
  input  logic [31:0]        pc_plus4_plusimm16,
  input  logic               alu_zero,
  input  logic               alu_not_zero,
  input  logic               alu_greater,
  input  logic [4:0]         reg_wr_addr,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               branch_eq,
  input  logic               branch_ne,
  input  logic               branch_gt,
  input  logic               reg_write,
  input  logic               mem_to_reg,
  stage4_mem_if.master       dmem,
  output logic               stall,
  output logic               pc_src,
  output logic [31:0]        branch_target,
  output logic               bus_err,
  output logic [31:0]        mem_rd_data_wb,
  output logic [31:0]        alu_result_wb,
  output logic [4:0]         reg_wr_addr_wb,
  output logic               reg_write_wb,
  output logic               mem_to_reg_wb
`ifdef ALIGN_CHECK_EN
  ,
  output logic               misalign
`endif
);

  logic op;
  logic misalign_now;
  logic op_eff;
  logic req;
  logic ctrl_stall;
  logic timeout;
  logic rd_ack;
  wb_t  wb_q, wb_d;

  assign op = mem_read | mem_write;

`ifdef ALIGN_CHECK_EN
  assign misalign_now = op & (alu_result[1:0] != 2'b00);
`else
  assign misalign_now = 1'b0;
`endif

  // An unaligned access never reaches memory and never stalls.
  assign op_eff = op & ~misalign_now;

  stage4_mem_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rstb      (rstb),
    .op_i      (op_eff),
    .ack_i     (dmem.dmem_ack),
    .req_o     (req),
    .stall_o   (ctrl_stall),
    .timeout_o (timeout),
    .bus_err_o (bus_err)
  );

  // Memory port: address, data and we are held stable by the upstream stall.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = mem_write;
  assign dmem.dmem_addr  = alu_result;
  assign dmem.dmem_wdata = regB_rd_data;

  assign stall         = ctrl_stall;
  assign pc_src        = branch_taken(branch_eq, branch_ne, branch_gt,
                                      alu_zero, alu_not_zero, alu_greater);
  assign branch_target = pc_plus4_plusimm16;

  // An ack only counts as read data while a read is actually requested.
  assign rd_ack = mem_read & op_eff & dmem.dmem_ack;

  // Write-back load: bubble while stalled or blocked, otherwise pass through.
  always_comb begin
    wb_d = wb_q;
    if (ctrl_stall || misalign_now) begin
      wb_d.reg_write  = 1'b0;
      wb_d.mem_to_reg = 1'b0;
    end else begin
      wb_d.alu_result  = alu_result;
      wb_d.reg_wr_addr = reg_wr_addr;
      wb_d.reg_write   = reg_write & ~timeout;
      wb_d.mem_to_reg  = mem_to_reg;
      if (rd_ack) begin
        wb_d.mem_rd_data = dmem.dmem_rdata;
      end else if (timeout) begin
        wb_d.mem_rd_data = TIMEOUT_RDATA;
      end
    end
  end

  // Write-back pipeline register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign mem_rd_data_wb = wb_q.mem_rd_data;
  assign alu_result_wb  = wb_q.alu_result;
  assign reg_wr_addr_wb = wb_q.reg_wr_addr;
  assign reg_write_wb   = wb_q.reg_write;
  assign mem_to_reg_wb  = wb_q.mem_to_reg;

`ifdef ALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle misalign pulse, aligned with the bubble it causes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_now;
    end
  end

  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_stage4_mem.sv
// tb_stage4_mem: self-checking bench for stage4_mem. Each memory access
// is described by its wait count; expected stall length, timeout, bus_err
// and write-back values are derived from that count and a running copy
// of the last written-back read data.
module tb_stage4_mem;
  import stage4_mem_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] alu_result, regB_rd_data, pc_plus4_plusimm16;
  logic        alu_zero, alu_not_zero, alu_greater;
  logic [4:0]  reg_wr_addr;
  logic        mem_read, mem_write, branch_eq, branch_ne, branch_gt;
  logic        reg_write, mem_to_reg;
  logic        stall, pc_src, bus_err;
  logic [31:0] branch_target, mem_rd_data_wb, alu_result_wb;
  logic [4:0]  reg_wr_addr_wb;
  logic        reg_write_wb, mem_to_reg_wb;
`ifdef ALIGN_CHECK_EN
  logic        misalign;
`endif

  stage4_mem_if dmem_bus ();

  stage4_mem #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk                (clk),
    .rstb               (rstb),
    .alu_result         (alu_result),
    .regB_rd_data       (regB_rd_data),
    .pc_plus4_plusimm16 (pc_plus4_plusimm16),
    .alu_zero           (alu_zero),
    .alu_not_zero       (alu_not_zero),
    .alu_greater        (alu_greater),
    .reg_wr_addr        (reg_wr_addr),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .branch_eq          (branch_eq),
    .branch_ne          (branch_ne),
    .branch_gt          (branch_gt),
    .reg_write          (reg_write),
    .mem_to_reg         (mem_to_reg),
    .dmem               (dmem_bus),
    .stall              (stall),
    .pc_src             (pc_src),
    .branch_target      (branch_target),
    .bus_err            (bus_err),
    .mem_rd_data_wb     (mem_rd_data_wb),
    .alu_result_wb      (alu_result_wb),
    .reg_wr_addr_wb     (reg_wr_addr_wb),
    .reg_write_wb       (reg_write_wb),
    .mem_to_reg_wb      (mem_to_reg_wb)
`ifdef ALIGN_CHECK_EN
    ,
    .misalign           (misalign)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rd   = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    reg_write          = 1'b0;
    mem_to_reg         = 1'b0;
    branch_eq          = 1'b0;
    branch_ne          = 1'b0;
    branch_gt          = 1'b0;
    dmem_bus.dmem_ack  = 1'b0;
  endtask

  // One access acked n_wait cycles after it is issued (never, if beyond TIMEOUT).
  task automatic run_txn(input bit is_rd, input int n_wait, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input bit rw, input bit m2r);
    int last;
    bit to;
    int stall_cnt;
    to        = (n_wait > TIMEOUT);
    last      = to ? TIMEOUT : n_wait;
    stall_cnt = 0;
    mem_read     = is_rd;
    mem_write    = !is_rd;
    alu_result   = addr;
    regB_rd_data = wdata;
    reg_wr_addr  = rd;
    reg_write    = rw;
    mem_to_reg   = m2r;
    for (int k = 0; k <= last; k++) begin
      dmem_bus.dmem_ack   = (k == n_wait);
      dmem_bus.dmem_rdata = (k == n_wait) ? rdata : $urandom();
      #1;
      if (stall === 1'b1) stall_cnt++;
      check("stall", stall, 32'(k < last));
      check("dmem_req", dmem_bus.dmem_req, 1);
      check("dmem_we", dmem_bus.dmem_we, 32'(!is_rd));
      if (k == 0) begin
        check("dmem_addr", dmem_bus.dmem_addr, addr);
        check("dmem_wdata", dmem_bus.dmem_wdata, wdata);
      end else begin
        check("wb_bubble", reg_write_wb, 0);
      end
      tick();
    end
    if (to) exp_rd = 32'h0;
    else if (is_rd) exp_rd = rdata;
    set_idle();
    check("stall_len", stall_cnt, last);
    check("alu_result_wb", alu_result_wb, addr);
    check("reg_wr_addr_wb", reg_wr_addr_wb, rd);
    check("reg_write_wb", reg_write_wb, 32'(rw && !to));
    check("mem_to_reg_wb", mem_to_reg_wb, 32'(m2r));
    check("mem_rd_data_wb", mem_rd_data_wb, exp_rd);
    check("bus_err", bus_err, 32'(to));
    tick();
    check("bus_err_once", bus_err, 0);
    check("rd_hold", mem_rd_data_wb, exp_rd);
    check("idle_reg_write_wb", reg_write_wb, 0);
  endtask

  initial begin
    logic [31:0] v;
    bit          exp_pc;

    set_idle();
    rstb               = 1'b1;
    alu_result         = '0;
    regB_rd_data       = '0;
    pc_plus4_plusimm16 = '0;
    alu_zero           = 1'b0;
    alu_not_zero       = 1'b0;
    alu_greater        = 1'b0;
    reg_wr_addr        = '0;
    dmem_bus.dmem_rdata = '0;

    // Reset values.
    #1 rstb = 1'b0;
    #2;
    check("rst_alu_result_wb", alu_result_wb, 0);
    check("rst_mem_rd_data_wb", mem_rd_data_wb, 0);
    check("rst_reg_write_wb", reg_write_wb, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_stall", stall, 0);
    tick();
    tick();
    rstb = 1'b1;
    tick();

    // Zero-wait load.
    run_txn(1'b1, 0, 32'h100, 32'h0, 32'hCAFEF00D, 5'd7, 1'b1, 1'b1);
    // Store acked after 3 cycles.
    run_txn(1'b0, 3, 32'h200, 32'h1234_5678, 32'h0, 5'd3, 1'b0, 1'b0);
    // Load with no ack: watchdog timeout.
    run_txn(1'b1, TIMEOUT + 4, 32'h300, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b1);
    // Ack on the timeout cycle: ack wins.
    run_txn(1'b1, TIMEOUT, 32'h304, 32'h0, 32'h5A5A_A5A5, 5'd10, 1'b1, 1'b1);

    // Branch resolution.
    branch_ne          = 1'b1;
    alu_not_zero       = 1'b1;
    pc_plus4_plusimm16 = 32'h40;
    #1;
    check("pc_src_ne", pc_src, 1);
    check("branch_target", branch_target, 32'h40);
    branch_ne   = 1'b0;
    branch_gt   = 1'b1;
    alu_greater = 1'b0;
    #1;
    check("pc_src_gt", pc_src, 0);
    for (int i = 0; i < 8; i++) begin
      v            = $urandom();
      branch_eq    = v[0];
      branch_ne    = v[1];
      branch_gt    = v[2];
      alu_zero     = v[3];
      alu_not_zero = v[4];
      alu_greater  = v[5];
      pc_plus4_plusimm16 = $urandom();
      exp_pc = (v[0] && v[3]) || (v[1] && v[4]) || (v[2] && v[5]);
      #1;
      check("pc_src_rand", pc_src, 32'(exp_pc));
      check("branch_target_rand", branch_target, pc_plus4_plusimm16);
    end
    set_idle();
    tick();

    // Ack with no request is ignored.
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h0BAD_0BAD;
    alu_result          = 32'h7777_0000;
    reg_write           = 1'b1;
    #1;
    check("stray_ack_req", dmem_bus.dmem_req, 0);
    check("stray_ack_stall", stall, 0);
    tick();
    check("stray_ack_rd", mem_rd_data_wb, exp_rd);
    check("stray_ack_alu", alu_result_wb, 32'h7777_0000);
    check("stray_ack_rw", reg_write_wb, 1);
    check("stray_ack_state", u_dut.u_ctrl.state_q, MEM_IDLE);
    set_idle();
    tick();

    // Randomized accesses.
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, TIMEOUT + 2),
              $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom(),
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

`ifdef ALIGN_CHECK_EN
    // Unaligned load is blocked and reported once.
    mem_read    = 1'b1;
    alu_result  = 32'h102;
    reg_write   = 1'b1;
    mem_to_reg  = 1'b1;
    #1;
    check("mis_req", dmem_bus.dmem_req, 0);
    check("mis_stall", stall, 0);
    tick();
    set_idle();
    check("mis_pulse", misalign, 1);
    check("mis_bubble", reg_write_wb, 0);
    tick();
    check("mis_once", misalign, 0);
`endif

    // Reset in the middle of a WAIT with the watchdog at 5.
    mem_read    = 1'b1;
    alu_result  = 32'h400;
    reg_write   = 1'b1;
    reg_wr_addr = 5'd4;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_cnt", u_dut.u_ctrl.cnt_q, 5);
    check("pre_rst_stall", stall, 1);
    rstb     = 1'b0;
    mem_read = 1'b0;
    reg_write = 1'b0;
    #1;
    check("mid_rst_state", u_dut.u_ctrl.state_q, MEM_IDLE);
    check("mid_rst_cnt", u_dut.u_ctrl.cnt_q, 0);
    check("mid_rst_req", dmem_bus.dmem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_alu_wb", alu_result_wb, 0);
    check("mid_rst_rd_wb", mem_rd_data_wb, 0);
    check("mid_rst_addr_wb", reg_wr_addr_wb, 0);
    check("mid_rst_bus_err", bus_err, 0);
    tick();
    rstb = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/stage4_mem.md
# stage4_mem

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the registered ALU result, store data, branch target, branch flags and write-register address. It drives a req/ack data-memory port and resolves branches. It registers results toward write-back and stalls upstream stages while a memory access is outstanding, bounding each access with a watchdog timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles a request may stay unacknowledged; legal range 2..255.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports (clk and rstb: one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rstb  in  1  asynchronous active-low reset.
- alu_result  in  32  effective address or pass-through result.
- regB_rd_data  in  32  store data.
- pc_plus4_plusimm16  in  32  branch target.
- alu_zero, alu_not_zero, alu_greater  in  1 each  branch condition flags.
- reg_wr_addr  in  5  destination register.
- mem_read, mem_write, branch_eq, branch_ne, branch_gt, reg_write, mem_to_reg  in  1 each  control bits from EX/MEM.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable; equals mem_write.
- dmem_addr  out  32  equals alu_result.
- dmem_wdata  out  32  equals regB_rd_data.
- dmem_rdata  in  32  read data; valid when dmem_ack is high.
- dmem_ack  in  1  completion strobe.
- stall  out  1  hold IF/ID/EX pipeline registers.
- pc_src  out  1  branch taken.
- branch_target  out  32  equals pc_plus4_plusimm16.
- bus_err  out  1  registered one-cycle timeout pulse.
- mem_rd_data_wb, alu_result_wb  out  32 each  registered to write-back.
- reg_wr_addr_wb  out  5  registered destination register.
- reg_write_wb, mem_to_reg_wb  out  1 each  registered write-back controls.

## Operation
- op = mem_read | mem_write; mem_read and mem_write are never both high (upstream guarantee).
- FSM states:
  - IDLE (reset state).
  - WAIT: request outstanding.
- Transitions:
  - IDLE→WAIT: op & !dmem_ack.
  - WAIT→IDLE: dmem_ack or timeout.
  - All other cases hold the current state.
- dmem_req = op in IDLE or WAIT (combinational). Address, data and we stay stable because stall freezes upstream.
- Watchdog counter:
  - Clears on entering WAIT and increments each WAIT cycle.
  - timeout = (state==WAIT) & (cnt==TIMEOUT-1) & !dmem_ack.
- stall = op & !dmem_ack & !timeout.
- Write-back register load (every edge):
  - If stall: bubble (reg_write_wb=0, mem_to_reg_wb=0; other WB regs hold).
  - Else: alu_result, reg_wr_addr, reg_write and mem_to_reg pass through; mem_rd_data_wb loads dmem_rdata on a read ack, 32'h0 on timeout, and holds otherwise.
- On timeout: bus_err=1 for the next cycle and reg_write_wb forced to 0.
- Branch resolution (combinational, never stalls): pc_src = (branch_eq&alu_zero) | (branch_ne&alu_not_zero) | (branch_gt&alu_greater).
- Simultaneous ack and timeout compare: ack wins and no bus_err is raised.
- dmem_ack outside a request is ignored.
- Reset mid-access: state→IDLE, counter→0, dmem_req drops as soon as the upstream control is reset.

## Timing
- Zero-wait memory (ack in the request cycle): no stall, and results appear at WB one edge later.
- N-wait memory: stall high for N cycles; the WB bubble is inserted during those cycles.
- Maximum stall is TIMEOUT cycles.
- Reset values: all *_wb outputs 0, bus_err 0, state IDLE, counter 0.
- pc_src, branch_target and dmem_* are combinational from inputs and state.

## Configuration
- ALIGN_CHECK_EN defined:
  - Adds output misalign (1 bit): op & (alu_result[1:0]!=0).
  - On misalign, dmem_req is suppressed and there is no stall.
  - The WB stage receives a bubble, and misalign is registered as a one-cycle pulse like bus_err.
- ALIGN_CHECK_EN undefined: no misalign port, and low address bits pass to dmem_addr unchecked.

## Structure
- Shared constants go in the pipeline defines file: FSM encodings (MEM_IDLE=1'b0, MEM_WAIT=1'b1) and the timeout read-data value 32'h0.
- One sub-module, stage4_mem_ctrl: FSM, watchdog counter, and stall/bus_err generation.
- The top instantiates stage4_mem_ctrl plus the existing register and mux_nbit cells for the WB registers and branch logic.

## Test plan
- Reset asserted mid-WAIT with the counter at 5: all outputs 0 and state IDLE immediately, without waiting for a clock.
- Load, addr 0x100, ack in the same cycle with rdata 0xCAFEF00D: stall never high; next cycle mem_rd_data_wb=0xCAFEF00D, reg_write_wb=1.
- Store, ack after 3 cycles: stall high exactly 3 cycles, dmem_we=1 throughout, reg_write_wb=0 during the stall, then a single completion.
- Load, no ack, TIMEOUT=16: stall drops after 16 cycles, bus_err pulses once, mem_rd_data_wb=0, reg_write_wb=0.
- branch_ne=1, alu_not_zero=1, target 0x40: pc_src=1 and branch_target=0x40 in the same cycle. The same with branch_gt=1, alu_greater=0 gives pc_src=0.
- ALIGN_CHECK_EN defined, load at addr 0x102: dmem_req stays 0, no stall, misalign pulses once.
